// File: rtl/lcd_cmd_scheduler.sv
// Round-robin command scheduler in front of LCD_CTRL: two requesters feed a
// shared FIFO, and an FSM issues one command at a time and tracks its completion.
module lcd_cmd_scheduler #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [3:0]             req0_cmd,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [3:0]             req1_cmd,
    output logic                   req1_ready,
    output logic [3:0]             cmd,
    output logic                   cmd_valid,
    input  logic                   lcd_busy,
    input  logic                   lcd_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   err_timeout,
    output logic [7:0]             issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, DRAIN} state_t;

    state_t        state, state_d;
    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          last_grant;
    logic          full, grant0, grant1, push, pop;
    logic [3:0]    push_cmd, cmd_d;
    logic          cmd_valid_d, seq_done_d, err_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [7:0]    issued_d;

    // last_grant == 1 means port 1 won most recently, so port 0 wins the next tie.
    always_comb begin
        full       = (level == LW'(DEPTH));
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = grant0 && !full;
        req1_ready = grant1 && !full;
        push       = req0_ready || req1_ready;
        push_cmd   = req0_ready ? req0_cmd : req1_cmd;
    end

    assign seq_busy = (state != IDLE);

    // NOTE: storage is deliberately not reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_cmd;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + LW'(1);
            else if (!push && pop) level <= level - LW'(1);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        cmd_d       = cmd;
        cmd_valid_d = 1'b0;
        seq_done_d  = 1'b0;
        err_d       = err_timeout;
        tcnt_d      = tcnt;
        issued_d    = issued_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && !lcd_busy) begin
                    cmd_d       = mem[rd_ptr];
                    cmd_valid_d = 1'b1;
                    pop         = 1'b1;
                    issued_d    = issued_cnt + 8'd1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = ACK;
            end
            ACK: begin
                if (lcd_busy) begin
                    state_d = DRAIN;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                    if (tcnt_d == TW'(ACK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Write-back (cmd 0) completes on done; everything else on busy falling.
                if (cmd == 4'd0 ? lcd_done : !lcd_busy) begin
                    seq_done_d = (cmd == 4'd0);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= 4'd0;
            cmd_valid   <= 1'b0;
            seq_done    <= 1'b0;
            err_timeout <= 1'b0;
            tcnt        <= '0;
            issued_cnt  <= 8'd0;
        end else begin
            state       <= state_d;
            cmd         <= cmd_d;
            cmd_valid   <= cmd_valid_d;
            seq_done    <= seq_done_d;
            err_timeout <= err_d;
            tcnt        <= tcnt_d;
            issued_cnt  <= issued_d;
        end
    end
endmodule
